// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexed driver for an N-digit common-anode seven-segment
//            display. Per-digit values, decimal points, blank and blink masks
//            are captured once per frame into shadow registers, so the display
//            never tears. One digit is scanned per slot. The first cycle of
//            every slot keeps all anodes off to stop ghosting. Supports hex
//            glyphs, leading-zero suppression and blinking.
// Ports    : clk          system clock
//            rst_n        asynchronous active-low reset
//            digits_in    4 bits per digit, digit 0 in [3:0] (rightmost)
//            dp_in        decimal point per digit, 1 = lit
//            blank_in     1 = digit fully dark, dp included
//            blink_in     1 = digit dark during blink-off phase, dp included
//            hex_en       1 = values 10..15 drawn as A-F, 0 = drawn dark
//            lz_en        leading-zero suppression enable
//            seg          {dp,g,f,e,d,c,b,a}, active low, registered
//            an           anode enables, active low, one-hot-low, registered
//            frame_start  one-cycle pulse on the cycle the shadows load
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      hex_en,
    input  logic                      lz_en,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);

    // Scan and blink state
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_FRM_W-1:0]        r_frm;
    logic                      r_blink_phase;   // 1 = off phase

    // Shadow copies of the inputs, refreshed once per frame
    logic [4*NUM_DIGITS-1:0]   r_sh_digits;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic [NUM_DIGITS-1:0]     r_sh_blank;
    logic [NUM_DIGITS-1:0]     r_sh_blink;
    logic                      r_sh_hex;
    logic                      r_sh_lz;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic [3:0]                w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:1]     w_zero_from;     // digit k and every digit above it are 0
    logic [NUM_DIGITS-1:1]     w_dp_above;      // some digit above k has its dp lit
    logic [NUM_DIGITS-1:0]     w_lz_mask;
    logic [3:0]                w_cur_val;
    logic                      w_dp_n;
    logic                      w_hide;
    logic [6:0]                w_glyph;
    logic [7:0]                w_seg_next;
    logic [NUM_DIGITS-1:0]     w_an_next;

    assign w_slot_end  = (r_cnt == c_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

    // Leading-zero suppression: walk down from the most significant digit.
    // A lit dp above a digit keeps that zero visible (e.g. "0.05").
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign w_digit[k] = r_sh_digits[4*k +: 4];
        if (k == 0) begin : g_lsd
            assign w_lz_mask[k] = 1'b0;
        end else begin : g_upper
            if (k == NUM_DIGITS - 1) begin : g_top
                assign w_zero_from[k] = (w_digit[k] == 4'd0);
                assign w_dp_above[k]  = 1'b0;
            end else begin : g_mid
                assign w_zero_from[k] = (w_digit[k] == 4'd0) && w_zero_from[k+1];
                assign w_dp_above[k]  = r_sh_dp[k+1] || w_dp_above[k+1];
            end
            assign w_lz_mask[k] = r_sh_lz && w_zero_from[k] && !w_dp_above[k];
        end
    end

    // Glyph for the digit currently being scanned
    always_comb begin
        w_cur_val = w_digit[r_idx];
        w_dp_n    = ~r_sh_dp[r_idx];
        w_hide    = r_sh_blank[r_idx] || (r_sh_blink[r_idx] && r_blink_phase);
        w_glyph   = 7'h7F;
        case (w_cur_val)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = r_sh_hex ? 7'h08 : 7'h7F;
            4'hB: w_glyph = r_sh_hex ? 7'h03 : 7'h7F;
            4'hC: w_glyph = r_sh_hex ? 7'h46 : 7'h7F;
            4'hD: w_glyph = r_sh_hex ? 7'h21 : 7'h7F;
            4'hE: w_glyph = r_sh_hex ? 7'h06 : 7'h7F;
            4'hF: w_glyph = r_sh_hex ? 7'h0E : 7'h7F;
            default: w_glyph = 7'h7F;
        endcase

        if (w_hide) begin
            w_seg_next = 8'hFF;
        end else if (w_lz_mask[r_idx]) begin
            w_seg_next = {w_dp_n, 7'h7F};
        end else begin
            w_seg_next = {w_dp_n, w_glyph};
        end

        // First cycle of each slot is dark so the previous digit cannot ghost
        w_an_next = '1;
        if (r_cnt != '0) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frm         <= '0;
            r_blink_phase <= 1'b0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_blank    <= '1;
            r_sh_blink    <= '0;
            r_sh_hex      <= 1'b0;
            r_sh_lz       <= 1'b0;
            seg           <= 8'hFF;
            an            <= '1;
            frame_start   <= 1'b0;
        end else begin
            seg         <= w_seg_next;
            an          <= w_an_next;
            frame_start <= w_frame_end;

            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_frame_end) begin
                r_sh_digits <= digits_in;
                r_sh_dp     <= dp_in;
                r_sh_blank  <= blank_in;
                r_sh_blink  <= blink_in;
                r_sh_hex    <= hex_en;
                r_sh_lz     <= lz_en;
                if (r_frm == c_FRM_LAST) begin
                    r_frm         <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frm <= r_frm + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Self-checking bench for seg_scan_driver (4 digits, 4-cycle slots,
//            2-frame blink half-period) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int BF = 2;
    localparam int RN = N * R;

    // Common-anode glyphs, index = digit value (dp bit replaced later)
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_in = '0;
    logic [N-1:0]  blink_in = '0;
    logic          hex_en = 1'b0;
    logic          lz_en = 1'b0;
    logic [7:0]    seg;
    logic [N-1:0]  an;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .hex_en     (hex_en),
        .lz_en      (lz_en),
        .seg        (seg),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: time since reset decides slot and digit; snapshots
    // of the inputs are taken at every frame boundary.
    // ------------------------------------------------------------------
    int            m_e = 0;       // clock edges since reset release
    int            m_loads = 0;   // frames loaded since reset
    int            m_cnt, m_idx;
    logic [3:0]    m_dig [N];
    logic [N-1:0]  m_dp, m_blank, m_blink;
    logic          m_hex, m_lz;
    logic [7:0]    exp_seg = 8'hFF;
    logic [N-1:0]  exp_an = '1;
    logic          exp_fs = 1'b0;

    function automatic logic [7:0] ref_glyph(input int k);
        bit   off_phase;
        bit   all_zero;
        bit   dp_above;
        logic dpbit;
        logic [7:0] g;
        off_phase = ((m_loads / BF) % 2) == 1;
        dpbit     = ~m_dp[k];
        if (m_blank[k] || (m_blink[k] && off_phase)) return 8'hFF;
        all_zero = 1'b1;
        dp_above = 1'b0;
        for (int j = k; j < N; j++) begin
            if (m_dig[j] != 4'd0) all_zero = 1'b0;
            if (j > k && m_dp[j]) dp_above = 1'b1;
        end
        if (m_lz && k != 0 && all_zero && !dp_above) return {dpbit, 7'h7F};
        if (m_dig[k] >= 4'd10 && !m_hex) g = 8'hFF;
        else g = GLYPH[m_dig[k]];
        return {dpbit, g[6:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0;
            m_loads = 0;
            for (int k = 0; k < N; k++) m_dig[k] = 4'd0;
            m_dp = '0; m_blank = '1; m_blink = '0; m_hex = 1'b0; m_lz = 1'b0;
            exp_seg = 8'hFF; exp_an = '1; exp_fs = 1'b0;
        end else begin
            m_cnt   = m_e % R;
            m_idx   = (m_e / R) % N;
            exp_an  = (m_cnt == 0) ? 4'hF : ~(4'(1) << m_idx);
            exp_seg = ref_glyph(m_idx);
            exp_fs  = (m_e % RN) == RN - 1;
            if (exp_fs) begin
                for (int k = 0; k < N; k++) m_dig[k] = digits_in[4*k +: 4];
                m_dp = dp_in; m_blank = blank_in; m_blink = blink_in;
                m_hex = hex_en; m_lz = lz_en;
                m_loads++;
            end
            m_e++;
        end
    end

    // Waits (bounded) for a DUT frame_start pulse; no comparisons here.
    task automatic wait_frame(output bit ok);
        int guard = 0;
        ok = 1'b0;
        while (!ok && guard < 3 * RN) begin
            @(negedge clk);
            guard++;
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int s, cnt, idx;
        logic [31:0] want;
        logic [3:0]  want_an;
        want = 32'h99B0A4F9;
        rst_n = 1'b0; digits_in = 16'h4321; dp_in = '0; blank_in = '0; blink_in = '0;
        hex_en = 1'b0; lz_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values an=%h seg=%h fs=%b expected an=f seg=ff fs=0", an, seg, frame_start);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * RN; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL reset_model e=%0d an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                         m_e, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            s = m_e - 1; cnt = s % R; idx = (s / R) % N;
            if (m_e <= RN) begin
                checks++;
                if (seg !== 8'hFF || frame_start !== (m_e == RN)) begin
                    errors++;
                    $display("FAIL first_frame e=%0d seg=%h fs=%b expected seg=ff fs=%b",
                             m_e, seg, frame_start, (m_e == RN));
                end
            end else begin
                want_an = (cnt == 0) ? 4'hF : ~(4'(1) << idx);
                checks++;
                if (an !== want_an || (cnt != 0 && seg !== want[8*idx +: 8])) begin
                    errors++;
                    $display("FAIL scan_4321 e=%0d an=%h seg=%h expected an=%h seg=%h",
                             m_e, an, seg, want_an, want[8*idx +: 8]);
                end
            end
        end
    endtask

    // Shared body for directed one-frame pattern checks
    task automatic frame_pattern(input string tag, input logic [31:0] want);
        bit ok;
        int s, cnt, idx;
        wait_frame(ok);
        checks++;
        if (!ok || (m_e % RN) != 0) begin
            errors++;
            $display("FAIL %s_frame_sync got_pulse=%b e=%0d expected pulse at frame boundary", tag, ok, m_e);
        end
        for (int c = 0; c < RN; c++) begin
            @(negedge clk);
            s = m_e - 1; cnt = s % R; idx = (s / R) % N;
            if (cnt != 0) begin
                checks++;
                if (an !== ~(4'(1) << idx) || seg !== want[8*idx +: 8]) begin
                    errors++;
                    $display("FAIL %s digit=%0d an=%h seg=%h expected an=%h seg=%h",
                             tag, idx, an, seg, ~(4'(1) << idx), want[8*idx +: 8]);
                end
            end
        end
    endtask

    task automatic test_lz_hex();
        digits_in = 16'h00A5; dp_in = '0; blank_in = '0; blink_in = '0;
        lz_en = 1'b1; hex_en = 1'b0;
        frame_pattern("lz_hex_off", 32'hFFFFFF92);
        hex_en = 1'b1;
        frame_pattern("lz_hex_on", 32'hFFFF8892);
    endtask

    task automatic test_dp_lz();
        digits_in = 16'h0000; dp_in = 4'b0100; lz_en = 1'b1; hex_en = 1'b0;
        // digit 3 suppressed, digit 2 suppressed but dp lit, digit 1 kept by dp above
        frame_pattern("dp_lz", 32'hFF7FC0C0);
    endtask

    task automatic test_blink();
        bit ok;
        int s, cnt, idx;
        logic [7:0] want;
        digits_in = 16'h0008; dp_in = '0; blink_in = 4'b0001; lz_en = 1'b0; hex_en = 1'b0;
        wait_frame(ok);
        for (int c = 0; c < 8 * RN; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL blink_model e=%0d an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                         m_e, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            s = m_e - 1; cnt = s % R; idx = (s / R) % N;
            if (idx == 0 && cnt != 0) begin
                want = (((m_loads / BF) % 2) == 1) ? 8'hFF : 8'h80;
                checks++;
                if (seg !== want) begin
                    errors++;
                    $display("FAIL blink_digit0 frame=%0d seg=%h expected %h", m_loads, seg, want);
                end
            end
        end
        blink_in = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 24 * RN; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL random_model e=%0d an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                         m_e, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < N; k++)
                    digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                blank_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                blink_in = 4'($urandom_range(0, 15));
                hex_en   = 1'($urandom_range(0, 1));
                lz_en    = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset_midscan();
        bit ok;
        digits_in = 16'h4321; dp_in = '0; blank_in = '0; blink_in = '0; hex_en = 1'b0; lz_en = 1'b0;
        wait_frame(ok);
        wait_frame(ok);
        for (int c = 0; c < RN - 2; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL midscan_model e=%0d an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                         m_e, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (m_e % RN == 6) digits_in = 16'h8888;
        end
        // Slot of digit 3 still shows the old value 4
        checks++;
        if (an !== 4'h7 || seg !== 8'h99) begin
            errors++;
            $display("FAIL midscan_old_value an=%h seg=%h expected an=7 seg=99", an, seg);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset an=%h seg=%h fs=%b expected an=f seg=ff fs=0", an, seg, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * RN; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL post_reset_model e=%0d an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                         m_e, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (m_e == 2) begin
                checks++;
                if (an !== 4'hE || seg !== 8'hFF) begin
                    errors++;
                    $display("FAIL post_reset_restart an=%h seg=%h expected an=e seg=ff", an, seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lz_hex();
        test_dp_lz();
        test_blink();
        test_random();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
